// File: rtl/axi_arb_pkg.sv
// Shared types and AW payload layout for the two-master AXI3 write arbiter.
// Payload packing (MSB first): {AWID[3:0], AWADDR[31:0], AWLEN[3:0], AWSIZE[2:0], AWBURST[1:0]}.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int unsigned AW_W        = 45;
  localparam int unsigned AWBURST_LSB = 0;
  localparam int unsigned AWSIZE_LSB  = 2;
  localparam int unsigned AWLEN_LSB   = 5;
  localparam int unsigned AWADDR_LSB  = 9;
  localparam int unsigned AWID_LSB    = 41;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  function automatic logic [3:0] aw_len(input logic [AW_W-1:0] aw);
    return aw[AWLEN_LSB +: 4];
  endfunction

  function automatic logic [AW_W-1:0] aw_pack(input logic [3:0]  id,
                                               input logic [31:0] addr,
                                               input logic [3:0]  len,
                                               input logic [2:0]  size,
                                               input logic [1:0]  burst);
    logic [AW_W-1:0] p;
    p = '0;
    p[AWID_LSB    +: 4]  = id;
    p[AWADDR_LSB  +: 32] = addr;
    p[AWLEN_LSB   +: 4]  = len;
    p[AWSIZE_LSB  +: 3]  = size;
    p[AWBURST_LSB +: 2]  = burst;
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the pointed-to requester wins if it requests, else the other one.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = i_req[i_rr] ? i_rr : ~i_rr;
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master, one-slave AXI3 write arbiter: grants one whole AW/W/B transaction at a time
// in round-robin order and flags WLAST arriving on a beat other than AWLEN.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned buswidth = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [1:0]                m_awvalid,
  output logic [1:0]                m_awready,
  input  logic [2*AW_W-1:0]         m_aw,
  input  logic [2*buswidth-1:0]     m_wdata,
  input  logic [2*(buswidth/8)-1:0] m_wstrb,
  input  logic [1:0]                m_wlast,
  input  logic [1:0]                m_wvalid,
  output logic [1:0]                m_wready,
  output logic [7:0]                m_bid,
  output logic [3:0]                m_bresp,
  output logic [1:0]                m_bvalid,
  input  logic [1:0]                m_bready,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [AW_W-1:0]           s_aw,
  output logic [buswidth-1:0]       s_wdata,
  output logic [buswidth/8-1:0]     s_wstrb,
  output logic                      s_wlast,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  input  logic [3:0]                s_bid,
  input  logic [1:0]                s_bresp,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic                      grant,
  output logic                      len_err
);

  localparam int unsigned SW = buswidth / 8;

  state_t          r_state, w_next;
  logic            r_rr;
  logic            r_grant;
  logic [AW_W-1:0] r_aw;
  logic [3:0]      r_cnt;

  logic                w_winner;
  logic                w_arb_valid;
  logic [AW_W-1:0]     w_aw_sel;
  logic [buswidth-1:0] w_wdata;
  logic [SW-1:0]       w_wstrb;
  logic                w_wlast;
  logic                w_wvalid;
  logic                w_bready;
  logic                w_beat;
  logic                w_bdone;

  rr_arbiter2 u_rr (
    .i_req    (m_awvalid),
    .i_rr     (r_rr),
    .o_winner (w_winner),
    .o_valid  (w_arb_valid)
  );

  // Mux views of the winning (IDLE) and granted (DATA/RESP) master.
  always_comb begin
    w_aw_sel = w_winner ? m_aw[2*AW_W-1:AW_W]        : m_aw[AW_W-1:0];
    w_wdata  = r_grant  ? m_wdata[2*buswidth-1:buswidth] : m_wdata[buswidth-1:0];
    w_wstrb  = r_grant  ? m_wstrb[2*SW-1:SW]          : m_wstrb[SW-1:0];
    w_wlast  = m_wlast[r_grant];
    w_wvalid = m_wvalid[r_grant];
    w_bready = m_bready[r_grant];
    w_beat   = w_wvalid && s_wready;
    w_bdone  = s_bvalid && w_bready;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_arb_valid)       w_next = ST_ADDR;
      ST_ADDR: if (s_awready)         w_next = ST_DATA;
      ST_DATA: if (w_beat && w_wlast) w_next = ST_RESP;
      ST_RESP: if (w_bdone)           w_next = ST_IDLE;
      default:                        w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rr    <= 1'b0;
      r_grant <= 1'b0;
      r_aw    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_arb_valid) begin
          r_grant <= w_winner;
          r_aw    <= w_aw_sel;
          r_cnt   <= '0;
        end
        ST_DATA: if (w_beat) r_cnt <= r_cnt + 4'd1;
        ST_RESP: if (w_bdone) r_rr <= ~r_grant;
        default: ;
      endcase
    end
  end

  // AW acceptance is combinational, so it is also gated by reset to keep outputs quiet.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bid     = '0;
    m_bresp   = '0;
    s_awvalid = 1'b0;
    s_aw      = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    len_err   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_arb_valid && !ARESET) m_awready[w_winner] = 1'b1;
      ST_ADDR: begin
        s_awvalid = 1'b1;
        s_aw      = r_aw;
      end
      ST_DATA: begin
        s_wdata           = w_wdata;
        s_wstrb           = w_wstrb;
        s_wlast           = w_wlast;
        s_wvalid          = w_wvalid;
        m_wready[r_grant] = s_wready;
        len_err           = w_beat && w_wlast && (r_cnt != aw_len(r_aw));
      end
      ST_RESP: begin
        m_bvalid[r_grant] = s_bvalid;
        s_bready          = w_bready;
        if (r_grant) begin
          m_bid[7:4]   = s_bid;
          m_bresp[3:2] = s_bresp;
        end else begin
          m_bid[3:0]   = s_bid;
          m_bresp[1:0] = s_bresp;
        end
      end
      default: ;
    endcase
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: the bench plays both masters and the slave cycle by cycle.
module tb_axi_write_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned BW = 32;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  m_awvalid, m_awready;
  logic [89:0] m_aw;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wlast, m_wvalid, m_wready;
  logic [7:0]  m_bid;
  logic [3:0]  m_bresp;
  logic [1:0]  m_bvalid, m_bready;
  logic        s_awvalid, s_awready;
  logic [44:0] s_aw;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic        grant, len_err;

  int unsigned n_chk;
  int unsigned n_bad;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.buswidth(BW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_aw      (m_aw),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_aw      (s_aw),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .grant     (grant),
    .len_err   (len_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full transaction from master m; the DUT is expected to be IDLE on entry and on exit.
  task automatic run_write(input int unsigned m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input int unsigned nbeats,
                           input int unsigned aw_stall, input bit gaps,
                           input int unsigned b_delay, input int unsigned bhold,
                           input logic [1:0] resp);
    logic [44:0] pay;
    logic [31:0] d;
    logic [3:0]  st;
    logic        last;
    pay = aw_pack(id, addr, len, 3'd2, 2'b01);
    m_aw[m*45 +: 45] = pay;
    m_awvalid[m]     = 1'b1;
    #1;
    chk("awready_idle", 64'(m_awready), 64'(1) << m);
    chk("s_awvalid_idle", 64'(s_awvalid), 64'd0);
    tick();
    m_awvalid[m] = 1'b0;
    for (int unsigned c = 0; c <= aw_stall; c++) begin
      s_awready = (c == aw_stall);
      #1;
      chk("s_awvalid", 64'(s_awvalid), 64'd1);
      chk("s_aw", 64'(s_aw), 64'(pay));
      chk("grant", 64'(grant), 64'(m));
      chk("awready_busy", 64'(m_awready), 64'd0);
      tick();
    end
    s_awready = 1'b0;
    for (int unsigned b = 0; b < nbeats; b++) begin
      d    = 32'hA000_0000 | (m << 16) | (32'(id) << 8) | b;
      st   = 4'hF ^ b[3:0];
      last = (b == nbeats - 1);
      m_wdata[m*32 +: 32] = d;
      m_wstrb[m*4 +: 4]   = st;
      m_wlast[m]          = last;
      if (gaps && b[0]) begin
        m_wvalid[m] = 1'b0;
        s_wready    = 1'b1;
        #1;
        chk("s_wvalid_gap", 64'(s_wvalid), 64'd0);
        chk("len_err_gap", 64'(len_err), 64'd0);
        tick();
        m_wvalid[m] = 1'b1;
        s_wready    = 1'b0;
        #1;
        chk("wready_gap", 64'(m_wready), 64'd0);
        chk("len_err_stall", 64'(len_err), 64'd0);
        tick();
      end
      m_wvalid[m] = 1'b1;
      s_wready    = 1'b1;
      #1;
      chk("s_wvalid", 64'(s_wvalid), 64'd1);
      chk("s_wdata", 64'(s_wdata), 64'(d));
      chk("s_wstrb", 64'(s_wstrb), 64'(st));
      chk("s_wlast", 64'(s_wlast), 64'(last));
      chk("m_wready", 64'(m_wready), 64'(1) << m);
      chk("len_err", 64'(len_err), 64'(last && (nbeats != 32'(len) + 1)));
      chk("awready_data", 64'(m_awready), 64'd0);
      tick();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m]  = 1'b0;
    s_wready    = 1'b0;
    m_bready[m] = 1'b1;
    for (int unsigned c = 0; c < b_delay; c++) begin
      #1;
      chk("bvalid_wait", 64'(m_bvalid), 64'd0);
      chk("s_bready_wait", 64'(s_bready), 64'd1);
      tick();
    end
    s_bvalid    = 1'b1;
    s_bid       = id;
    s_bresp     = resp;
    m_bready[m] = 1'b0;
    for (int unsigned c = 0; c < bhold; c++) begin
      #1;
      chk("s_bready_hold", 64'(s_bready), 64'd0);
      chk("bvalid_hold", 64'(m_bvalid), 64'(1) << m);
      tick();
    end
    m_bready[m] = 1'b1;
    #1;
    chk("m_bvalid", 64'(m_bvalid), 64'(1) << m);
    chk("m_bid", 64'(m_bid), 64'(id) << (4 * m));
    chk("m_bresp", 64'(m_bresp), 64'(resp) << (2 * m));
    chk("s_bready", 64'(s_bready), 64'd1);
    chk("awready_resp", 64'(m_awready), 64'd0);
    tick();
    s_bvalid    = 1'b0;
    s_bid       = '0;
    s_bresp     = '0;
    m_bready[m] = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    ARESET    = 1'b1;
    m_awvalid = '0;
    m_aw      = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bid     = '0;
    s_bresp   = '0;
    s_bvalid  = 1'b0;
    tick();
    tick();
    chk("rst_awready", 64'(m_awready), 64'd0);
    chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    ARESET = 1'b0;
    tick();
    #1;
    chk("idle_awready", 64'(m_awready), 64'd0);
    chk("idle_s_wvalid", 64'(s_wvalid), 64'd0);

    // Single write from master 0, AWLEN=3, AWID=5.
    run_write(0, 4'h5, 32'h0000_1000, 4'd3, 4, 0, 1'b0, 0, 0, BRESP_OKAY);

    // Master 1 write cut short by reset in the middle of DATA.
    m_aw[89:45]  = aw_pack(4'h9, 32'h0000_2000, 4'd3, 3'd2, 2'b01);
    m_awvalid[1] = 1'b1;
    #1;
    chk("abort_awready", 64'(m_awready), 64'h2);
    tick();
    m_awvalid[1] = 1'b0;
    s_awready    = 1'b1;
    #1;
    chk("abort_s_awvalid", 64'(s_awvalid), 64'd1);
    tick();
    s_awready     = 1'b0;
    m_wvalid[1]   = 1'b1;
    m_wdata[63:32] = 32'h1234_5678;
    s_wready      = 1'b1;
    #1;
    chk("abort_wready", 64'(m_wready), 64'h2);
    tick();
    tick();
    ARESET = 1'b1;
    #1;
    chk("mid_rst_wready", 64'(m_wready), 64'd0);
    chk("mid_rst_s_wvalid", 64'(s_wvalid), 64'd0);
    chk("mid_rst_s_wdata", 64'(s_wdata), 64'd0);
    chk("mid_rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("mid_rst_s_aw", 64'(s_aw), 64'd0);
    chk("mid_rst_bvalid", 64'(m_bvalid), 64'd0);
    chk("mid_rst_s_bready", 64'(s_bready), 64'd0);
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_len_err", 64'(len_err), 64'd0);
    m_wvalid = '0;
    s_wready = 1'b0;
    tick();
    ARESET = 1'b0;
    tick();

    // Both masters keep requesting: grants must alternate 0,1,0,1,0,1.
    for (int unsigned k = 0; k < 6; k++) begin
      int unsigned m;
      m = k % 2;
      if (k < 5) m_awvalid[1-m] = 1'b1;
      run_write(m, 4'(k + 1), 32'h0000_3000 + 32'(k * 64), 4'(k % 3), k % 3 + 1,
                0, 1'b0, 0, 0, BRESP_OKAY);
    end

    // Slave back-pressure on every channel.
    run_write(0, 4'hA, 32'h0000_4000, 4'd3, 4, 5, 1'b1, 4, 0, BRESP_OKAY);
    // Early WLAST: AWLEN=2 but only two beats.
    run_write(1, 4'h3, 32'h0000_5000, 4'd2, 2, 0, 1'b0, 0, 0, BRESP_OKAY);
    // Longest burst, no error expected.
    run_write(0, 4'hF, 32'h0000_6000, 4'd15, 16, 0, 1'b0, 0, 0, BRESP_OKAY);
    // Late WLAST: AWLEN=1 but three beats.
    run_write(0, 4'h7, 32'h0000_7000, 4'd1, 3, 0, 1'b0, 1, 0, BRESP_OKAY);
    // Master 1 holds BREADY low for 6 cycles against a waiting BVALID.
    run_write(1, 4'hC, 32'h0000_8000, 4'd0, 1, 0, 1'b0, 0, 6, 2'b10);

    #1;
    chk("end_awready", 64'(m_awready), 64'd0);
    chk("end_s_awvalid", 64'(s_awvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
